// File: rtl/ip1_test_pkg.sv
// Shared types and constants for the IP1 test sequencer: state encoding, pin bundle layout,
// and the idle pin value presented when no test owns the ASIC pins.
package ip1_test_pkg;

  localparam int NUM_TESTS      = 15;
  localparam int PINS_PER_TEST  = 7;
  localparam int TIMEOUT_W      = 24;

  localparam int PIN_CONFIG_CLK = 0;
  localparam int PIN_RESET_NOT  = 1;
  localparam int PIN_CONFIG_IN  = 2;
  localparam int PIN_CONFIG_LD  = 3;
  localparam int PIN_VIN_TRIG   = 4;
  localparam int PIN_SCAN_IN    = 5;
  localparam int PIN_SCAN_LOAD  = 6;

  // reset_not and config_load held high, everything else low.
  localparam logic [PINS_PER_TEST-1:0] IDLE_PINS = 7'h0A;

  typedef logic [NUM_TESTS-1:0] test_vec_t;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SELECT = 3'd1,
    ST_LAUNCH = 3'd2,
    ST_RUN    = 3'd3,
    ST_NEXT   = 3'd4,
    ST_DONE   = 3'd5
  } seq_state_e;

  // Index of the lowest set bit; scanning downward lets the lowest hit win.
  function automatic logic [3:0] lowest_set_idx(input test_vec_t v);
    logic [3:0] idx;
    idx = 4'd0;
    for (int i = NUM_TESTS - 1; i >= 0; i--) begin
      if (v[i]) idx = i[3:0];
    end
    return idx;
  endfunction

endpackage

// File: rtl/ip1_test_sequencer_if.sv
// Control/status bundle between the AXI register block and the IP1 test sequencer.
// timeout_max exists only when IP1_TEST_SEQ_TIMEOUT_EN is defined.
interface ip1_test_sequencer_if;
  import ip1_test_pkg::*;

  logic                                    start;
  logic                                    abort;
  test_vec_t                               test_mask;
`ifdef IP1_TEST_SEQ_TIMEOUT_EN
  logic [TIMEOUT_W-1:0]                    timeout_max;
`endif
  test_vec_t                               test_status_done;
  logic [NUM_TESTS*PINS_PER_TEST-1:0]      test_pins_i;

  test_vec_t                               test_enable;
  test_vec_t                               test_enable_re;
  logic [PINS_PER_TEST-1:0]                asic_pins_o;
  logic                                    busy;
  logic                                    done;
  logic                                    aborted;
  test_vec_t                               fail_mask;
  logic [3:0]                              current_test;
  logic [2:0]                              seq_state;

  modport master (
`ifdef IP1_TEST_SEQ_TIMEOUT_EN
    output timeout_max,
`endif
    output start, abort, test_mask, test_status_done, test_pins_i,
    input  test_enable, test_enable_re, asic_pins_o, busy, done, aborted,
    input  fail_mask, current_test, seq_state
  );

  modport slave (
`ifdef IP1_TEST_SEQ_TIMEOUT_EN
    input  timeout_max,
`endif
    input  start, abort, test_mask, test_status_done, test_pins_i,
    output test_enable, test_enable_re, asic_pins_o, busy, done, aborted,
    output fail_mask, current_test, seq_state
  );

endinterface

// File: rtl/ip1_test_pin_mux.sv
// Routes the pin bundle of the enabled test to the ASIC pins; idle value when no test is enabled.
module ip1_test_pin_mux
  import ip1_test_pkg::*;
(
  input  test_vec_t                           test_enable_i,
  input  logic [NUM_TESTS*PINS_PER_TEST-1:0]  test_pins_i,
  output logic [PINS_PER_TEST-1:0]            asic_pins_o
);

  // NOTE: assigning a default before the loop keeps this purely combinational (no latch).
  always_comb begin
    asic_pins_o = IDLE_PINS;
    for (int k = 0; k < NUM_TESTS; k++) begin
      if (test_enable_i[k]) asic_pins_o = test_pins_i[k*PINS_PER_TEST +: PINS_PER_TEST];
    end
  end

endmodule

// File: rtl/ip1_test_sequencer.sv
// Runs the masked IP1 tests one at a time in ascending order, muxing each test's pins to the ASIC.
// Define IP1_TEST_SEQ_TIMEOUT_EN to add the per-test RUN watchdog and fail_mask reporting.
module ip1_test_sequencer
  import ip1_test_pkg::*;
(
  input  logic                 clk,
  input  logic                 reset_not,
  ip1_test_sequencer_if.slave  bus
);

  seq_state_e  state_q, state_d;
  test_vec_t   pending_q, pending_d;
  test_vec_t   enable_q, enable_d;
  test_vec_t   status_q;
  logic [3:0]  idx_q, idx_d;
  logic        launch2_q, launch2_d;
  logic        start_q;
  logic        aborted_q, aborted_d;
  logic        start_re;
  logic        done_re;
`ifdef IP1_TEST_SEQ_TIMEOUT_EN
  logic [TIMEOUT_W-1:0] cnt_q, cnt_d;
  logic [TIMEOUT_W-1:0] cnt_inc;
  test_vec_t            fail_q, fail_d;
`endif

  assign start_re = bus.start & ~start_q;
  assign done_re  = bus.test_status_done[idx_q] & ~status_q[idx_q];
`ifdef IP1_TEST_SEQ_TIMEOUT_EN
  assign cnt_inc  = cnt_q + {{(TIMEOUT_W-1){1'b0}}, 1'b1};
`endif

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge reset_not) begin
    if (!reset_not) begin
      state_q   <= ST_IDLE;
      pending_q <= '0;
      enable_q  <= '0;
      status_q  <= '0;
      idx_q     <= 4'd0;
      launch2_q <= 1'b0;
      start_q   <= 1'b0;
      aborted_q <= 1'b0;
`ifdef IP1_TEST_SEQ_TIMEOUT_EN
      cnt_q     <= '0;
      fail_q    <= '0;
`endif
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
      enable_q  <= enable_d;
      status_q  <= bus.test_status_done;
      idx_q     <= idx_d;
      launch2_q <= launch2_d;
      start_q   <= bus.start;
      aborted_q <= aborted_d;
`ifdef IP1_TEST_SEQ_TIMEOUT_EN
      cnt_q     <= cnt_d;
      fail_q    <= fail_d;
`endif
    end
  end

  always_comb begin
    state_d   = state_q;
    pending_d = pending_q;
    enable_d  = enable_q;
    idx_d     = idx_q;
    launch2_d = 1'b0;
    aborted_d = aborted_q;
`ifdef IP1_TEST_SEQ_TIMEOUT_EN
    cnt_d     = cnt_q;
    fail_d    = fail_q;
`endif

    if (bus.abort) begin
      state_d   = ST_IDLE;
      enable_d  = '0;
      pending_d = '0;
      aborted_d = 1'b1;
    end else begin
      case (state_q)
        ST_IDLE, ST_DONE: begin
          if (start_re) begin
            pending_d = bus.test_mask;
            aborted_d = 1'b0;
`ifdef IP1_TEST_SEQ_TIMEOUT_EN
            fail_d    = '0;
`endif
            state_d   = ST_SELECT;
          end
        end
        ST_SELECT: begin
          if (|pending_q) begin
            idx_d    = lowest_set_idx(pending_q);
            enable_d = test_vec_t'(1) << lowest_set_idx(pending_q);
            state_d  = ST_LAUNCH;
          end else begin
            state_d  = ST_DONE;
          end
        end
        // Two cycles: enable settles first, the start pulse follows on the second.
        ST_LAUNCH: begin
`ifdef IP1_TEST_SEQ_TIMEOUT_EN
          cnt_d = '0;
`endif
          if (!launch2_q) launch2_d = 1'b1;
          else            state_d   = ST_RUN;
        end
        ST_RUN: begin
          if (done_re) begin
            state_d = ST_NEXT;
          end
`ifdef IP1_TEST_SEQ_TIMEOUT_EN
          else if ((bus.timeout_max != '0) && (cnt_inc == bus.timeout_max)) begin
            fail_d[idx_q] = 1'b1;
            state_d       = ST_NEXT;
          end else begin
            cnt_d = cnt_inc;
          end
`endif
        end
        ST_NEXT: begin
          enable_d         = '0;
          pending_d[idx_q] = 1'b0;
          state_d          = ST_SELECT;
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  assign bus.test_enable    = enable_q;
  assign bus.test_enable_re = (state_q == ST_LAUNCH && launch2_q) ? enable_q : '0;
  assign bus.busy           = state_q inside {ST_SELECT, ST_LAUNCH, ST_RUN, ST_NEXT};
  assign bus.done           = (state_q == ST_DONE);
  assign bus.aborted        = aborted_q;
  assign bus.current_test   = (state_q inside {ST_LAUNCH, ST_RUN, ST_NEXT}) ? idx_q + 4'd1 : 4'd0;
  assign bus.seq_state      = state_q;
`ifdef IP1_TEST_SEQ_TIMEOUT_EN
  assign bus.fail_mask      = fail_q;
`else
  assign bus.fail_mask      = '0;
`endif

  ip1_test_pin_mux u_pin_mux (
    .test_enable_i (enable_q),
    .test_pins_i   (bus.test_pins_i),
    .asic_pins_o   (bus.asic_pins_o)
  );

endmodule

// File: doc/ip1_test_sequencer.md
IP1_TEST_SEQUENCER -- requirements
Module: ip1_test_sequencer

Interface
- REQ-001 clk  in  1  FM clock 100 MHz (S_AXI_ACLK); the block has one clock, and reset is asynchronous and active-low.
- REQ-002 reset_not  in  1  asynchronous active-low reset.
- REQ-003 start  in  1  level from AXI register; only a rising edge is acted on.
- REQ-004 abort  in  1  level; while high, forces return to IDLE.
- REQ-005 test_mask  in  15  bit k selects test k+1 for the batch.
- REQ-006 timeout_max  in  24  watchdog limit in clk cycles (present only with the macro).
- REQ-007 test_status_done  in  15  per-test status_done flag.
- REQ-008 test_pins_i  in  105  7 bits per test k at [7k+6:7k]; bit order: config_clk, reset_not, config_in, config_load, vin_test_trig_out, scan_in, scan_load.
- REQ-009 test_enable  out  15  one-hot level enable to the test FSMs.
- REQ-010 test_enable_re  out  15  one-hot single-cycle start pulse.
- REQ-011 asic_pins_o  out  7  muxed ASIC pin bundle, same bit order as REQ-008.
- REQ-012 busy, done, aborted  out  1 each  status flags.
- REQ-013 fail_mask  out  15  tests that timed out; current_test  out  4  index+1, 0 when none; seq_state  out  3  state code.

Function
- REQ-014 States: IDLE=0, SELECT=1, LAUNCH=2, RUN=3, NEXT=4, DONE=5; unused codes SHALL go to IDLE.
- REQ-015 In IDLE or DONE, a start rising edge SHALL capture test_mask into a pending register, clear fail_mask and done, and move to SELECT.
- REQ-016 SELECT: the lowest set pending bit k SHALL go to LAUNCH with current_test=k+1; if no bit is pending, go to DONE.
- REQ-017 LAUNCH: test_enable[k]=1 on entry; test_enable_re[k]=1 for exactly one clk, on the second LAUNCH cycle; then RUN.
- REQ-018 RUN: a 0->1 edge on test_status_done[k] SHALL go to NEXT; other done bits SHALL be ignored.
- REQ-019 NEXT: clear test_enable and pending bit k, then SELECT; tests run in ascending index order.
- REQ-020 DONE: done=1 held; busy=0; current_test=0. busy=1 in SELECT, LAUNCH, RUN and NEXT.
- REQ-021 asic_pins_o SHALL be a combinational mux of test k's pins while test_enable[k]=1; otherwise idle value 7'h0A (reset_not=1, config_load=1, all others 0).
- REQ-022 start edges while busy SHALL be ignored; test_mask changes after capture SHALL be ignored.
- REQ-023 abort=1 in any state SHALL, on the next clk, move to IDLE, zero test_enable/test_enable_re, set aborted=1 and clear busy; aborted clears on the next accepted start.
- REQ-024 A start captured with mask 0 SHALL reach DONE via SELECT with fail_mask=0.

Reset
- REQ-025 reset_not low SHALL asynchronously set state IDLE; all outputs 0 except asic_pins_o=7'h0A; pending register and edge detectors 0.
- REQ-026 Reset mid-run SHALL drop test_enable immediately (asynchronously).

Configuration
- REQ-027 IP1_TEST_SEQ_TIMEOUT_EN defined: a 24-bit RUN counter clears on LAUNCH; reaching timeout_max sets fail_mask[k] and goes to NEXT; timeout_max=0 disables the watchdog.
- REQ-028 IP1_TEST_SEQ_TIMEOUT_EN undefined: no timeout_max port, no counter, fail_mask tied to 0; RUN waits indefinitely.

Structure
- REQ-029 Package ip1_test_pkg SHALL hold the state enum, the pin-bit index constants, the idle pin value 7'h0A and the NUM_TESTS=15 constant.
- REQ-030 Sub-module ip1_test_pin_mux SHALL implement the REQ-021 mux.

Verification
- REQ-031 mask=15'h0005, tests answer done 50 clk after enable_re -> enable_re pulses for test1 then test3; done=1; fail_mask=0.
- REQ-032 With the macro, mask=15'h0002, timeout_max=100, no done -> fail_mask=15'h0002 exactly 100 clk after LAUNCH exit; DONE.
- REQ-033 abort asserted during RUN of test 2 -> next clk IDLE, test_enable=0, aborted=1, asic_pins_o=7'h0A.
- REQ-034 Second start edge during RUN, and mask changed mid-batch -> both ignored; original sequence completes.
- REQ-035 reset_not pulsed low between clk edges during RUN -> outputs at reset values before the next edge.
- REQ-036 test_status_done[k] already 1 at launch -> no NEXT until that bit falls and rises again.
